// File: rtl/tsic_mc_cntrl_if.sv
// Command/A2D/EEPROM/transmit signal bundle for tsic_mc_cntrl.
// NUM_CH must match the NUM_CH of the controller the bundle is attached to.
interface tsic_mc_cntrl_if #(
  parameter int NUM_CH = 4
);
  localparam int CH_W = $clog2(NUM_CH);

  logic            cmd_rdy;
  logic [CH_W+1:0] cmd;
  logic            cmplt;
  logic            tx_done;
  logic            strt;
  logic [CH_W-1:0] ch_sel;
  logic            WE;
  logic [CH_W:0]   addr;
  logic            wrtTmp;
  logic            mult;
  logic            trmt;
  logic            busy;
  logic            err;

  modport master (
    input  cmd_rdy, cmd, cmplt, tx_done,
    output strt, ch_sel, WE, addr, wrtTmp, mult, trmt, busy, err
  );

  modport slave (
    output cmd_rdy, cmd, cmplt, tx_done,
    input  strt, ch_sel, WE, addr, wrtTmp, mult, trmt, busy, err
  );
endinterface

// File: rtl/tsic_mc_cntrl.sv
// Multi-channel temperature sensor controller: calibration writes, per-channel
// or sweep conversion sequencing with conversion timeout, and transmit handshake.
module tsic_mc_cntrl #(
  parameter int NUM_CH  = 4,
  parameter int TMO_CYC = 1024
) (
  input logic             clk,
  input logic             rst_n,
  tsic_mc_cntrl_if.master bus
);
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(TMO_CYC);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);
  localparam logic [1:0] OP_CONV  = 2'b10;
  localparam logic [1:0] OP_SWEEP = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_CAL  = 3'd1,
    ST_CONV    = 3'd2,
    ST_OFFS    = 3'd3,
    ST_GAIN    = 3'd4,
    ST_XMIT    = 3'd5,
    ST_TX_WAIT = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [CH_W-1:0]  ch_sel_q, ch_sel_d;
  logic             sweep_q, sweep_d;
  logic             err_q, err_d;
  logic             cal_sel_q, cal_sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             strt_s;

  logic             we_q, we_d;
  logic [CH_W:0]    addr_q, addr_d;
  logic             wrt_tmp_q, wrt_tmp_d;
  logic             mult_q, mult_d;
  logic             trmt_q, trmt_d;
  logic             busy_q, busy_d;

  logic [1:0]       op_s;
  logic [CH_W-1:0]  cmd_ch_s;
  logic             ch_ok_s;

  assign op_s     = bus.cmd[CH_W+1:CH_W];
  assign cmd_ch_s = bus.cmd[CH_W-1:0];
  // Widened compare so the range check stays meaningful when NUM_CH is a power of two.
  assign ch_ok_s  = ({1'b0, cmd_ch_s} < (CH_W+1)'(NUM_CH));

  // Next-state, channel bookkeeping, timeout counter and Mealy strt.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    ch_sel_d  = ch_sel_q;
    sweep_d   = sweep_q;
    err_d     = err_q;
    cal_sel_d = cal_sel_q;
    cnt_d     = '0;
    strt_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_rdy) begin
          if ((op_s != OP_SWEEP) && !ch_ok_s) begin
            err_d = 1'b1;
          end else begin
            err_d     = 1'b0;
            cal_sel_d = op_s[0];
            if (op_s == OP_SWEEP) begin
              ch_d     = '0;
              ch_sel_d = '0;
              sweep_d  = 1'b1;
              strt_s   = 1'b1;
              state_d  = ST_CONV;
            end else if (op_s == OP_CONV) begin
              ch_d     = cmd_ch_s;
              ch_sel_d = cmd_ch_s;
              sweep_d  = 1'b0;
              strt_s   = 1'b1;
              state_d  = ST_CONV;
            end else begin
              ch_d    = cmd_ch_s;
              sweep_d = 1'b0;
              state_d = ST_WR_CAL;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR_CAL: state_d = ST_TX_WAIT;
      ST_CONV: begin
        // A cmplt arriving in the last allowed cycle still counts as success.
        if (bus.cmplt) begin
          state_d = ST_OFFS;
        end else if (cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          sweep_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_OFFS: state_d = ST_GAIN;
      ST_GAIN: state_d = ST_XMIT;
      ST_XMIT: state_d = ST_TX_WAIT;
      ST_TX_WAIT: begin
        if (bus.tx_done) begin
          if (sweep_q && (ch_q < LAST_CH)) begin
            ch_d     = ch_q + CH_W'(1);
            ch_sel_d = ch_q + CH_W'(1);
            strt_s   = 1'b1;
            state_d  = ST_CONV;
          end else begin
            sweep_d = 1'b0;
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_TX_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every Moore output leaves a flop.
  always_comb begin
    we_d      = 1'b0;
    addr_d    = '0;
    wrt_tmp_d = 1'b0;
    mult_d    = 1'b0;
    trmt_d    = 1'b0;
    busy_d    = (state_d != ST_IDLE);
    case (state_d)
      ST_WR_CAL: begin
        we_d   = 1'b1;
        addr_d = {ch_d, cal_sel_d};
        trmt_d = 1'b1;
      end
      ST_OFFS: begin
        wrt_tmp_d = 1'b1;
        addr_d    = {ch_d, 1'b0};
      end
      ST_GAIN: begin
        wrt_tmp_d = 1'b1;
        mult_d    = 1'b1;
        addr_d    = {ch_d, 1'b1};
      end
      ST_XMIT: begin
        trmt_d = 1'b1;
        mult_d = 1'b1;
        addr_d = {ch_d, 1'b1};
      end
      default: addr_d = '0;
    endcase
  end

  // State, bookkeeping and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ch_q      <= '0;
      ch_sel_q  <= '0;
      sweep_q   <= 1'b0;
      err_q     <= 1'b0;
      cal_sel_q <= 1'b0;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wrt_tmp_q <= 1'b0;
      mult_q    <= 1'b0;
      trmt_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      ch_sel_q  <= ch_sel_d;
      sweep_q   <= sweep_d;
      err_q     <= err_d;
      cal_sel_q <= cal_sel_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wrt_tmp_q <= wrt_tmp_d;
      mult_q    <= mult_d;
      trmt_q    <= trmt_d;
      busy_q    <= busy_d;
    end
  end

  // strt is Mealy; masking with rst_n keeps it quiet while reset is held.
  assign bus.strt   = strt_s & rst_n;
  assign bus.ch_sel = ch_sel_q;
  assign bus.WE     = we_q;
  assign bus.addr   = addr_q;
  assign bus.wrtTmp = wrt_tmp_q;
  assign bus.mult   = mult_q;
  assign bus.trmt   = trmt_q;
  assign bus.busy   = busy_q;
  assign bus.err    = err_q;
endmodule

// File: doc/tsic_mc_cntrl.md
# tsic_mc_cntrl

Multi-channel successor to the single-sensor temperature controller: decodes commands from the serial comm block, writes per-channel offset/gain calibration into EEPROM, sequences A2D conversion plus the offset-add / gain-multiply datapath for a selected channel, and hands results to the serial transmitter. It adds channel addressing, an all-channel sweep mode, a conversion timeout with error flag, and a transmit-done handshake. It sits between the UART command/transmit logic and the A2D / EEPROM / temp-register datapath.

## Interface
- NUM_CH, 4, number of sensor channels (2..16); CH_W = $clog2(NUM_CH)
- TMO_CYC, 1024, max cycles in CONV awaiting cmplt before timeout (>=2)

- clk  in  1  system clock
- rst_n  in  1  reset; one clock, reset is synchronous and active-low
- cmd_rdy  in  1  command valid pulse from serial comm
- cmd  in  CH_W+2  [CH_W+1:CH_W] opcode, [CH_W-1:0] channel
- cmplt  in  1  A2D conversion complete
- tx_done  in  1  serial transmitter finished current frame
- strt  out  1  start A2D conversion (1-cycle pulse)
- ch_sel  out  CH_W  A2D input mux select; registered, held during conversion
- WE  out  1  EEPROM write enable
- addr  out  CH_W+1  EEPROM address {channel, sel}; sel 0=offset, 1=gain
- wrtTmp  out  1  load temp register with datapath result
- mult  out  1  datapath op: 0 = A2D+offset[addr], 1 = tmp*gain[addr]
- trmt  out  1  start transmit (1-cycle pulse)
- busy  out  1  state != IDLE
- err  out  1  sticky error flag

## Operation
- Opcodes: 00 write offset, 01 write gain, 10 convert channel, 11 sweep all channels (channel field ignored, starts at 0).
- States: IDLE, WR_CAL, CONV, OFFS, GAIN, XMIT, TX_WAIT. All outputs default 0 each cycle.
- IDLE: cmd_rdy sampled only here. Channel >= NUM_CH on opcode 00/01/10 -> err=1, stay IDLE, no other output. Valid command: err cleared, channel registered into ch. 00/01 -> WR_CAL. 10/11 -> strt=1 same cycle (Mealy), ch_sel takes new channel next cycle, -> CONV; sweep flag = (opcode==11).
- WR_CAL (1 cycle): WE=1, addr={ch, op[0]}, trmt=1 -> TX_WAIT.
- CONV: cycle counter cleared on entry. cmplt -> OFFS. Counter reaching TMO_CYC-1 without cmplt -> err=1, sweep aborted, -> IDLE, no trmt. cmplt in the timeout cycle wins.
- OFFS (1 cycle): wrtTmp=1, mult=0, addr={ch,0} -> GAIN.
- GAIN (1 cycle): wrtTmp=1, mult=1, addr={ch,1} -> XMIT.
- XMIT (1 cycle): trmt=1, mult=1, addr={ch,1} held -> TX_WAIT.
- TX_WAIT: waits for tx_done (not sampled in XMIT/WR_CAL cycle). On tx_done: sweep and ch<NUM_CH-1 -> ch+1, strt=1, -> CONV; else -> IDLE, sweep cleared.
- cmd_rdy outside IDLE is dropped, not queued.

## Timing
- Reset: state IDLE, ch=0, ch_sel=0, sweep=0, err=0; all outputs 0. Reset mid-operation aborts immediately; no strt/WE/trmt after reset asserted.
- Write latency: cmd_rdy cycle 0 -> WE/trmt cycle 1; busy from cycle 1 until cycle after tx_done.
- Convert latency: strt on cmd_rdy cycle; cmplt at cycle k -> OFFS k+1, GAIN k+2, trmt k+3.
- Sweep: next strt in same cycle tx_done seen; exactly NUM_CH trmt pulses; ch_sel increments once per channel, never wraps.
- Timeout: err rises on cycle after the TMO_CYC-th CONV cycle; busy falls same edge.
- strt, WE, trmt, wrtTmp never asserted more than one cycle per state visit.

## Test plan
- NUM_CH=4: reset, cmd=4'b0110 with cmd_rdy -> next cycle WE=1, addr=3'b101, trmt=1; busy=1 until tx_done, then IDLE.
- cmd=4'b1011 -> strt same cycle, ch_sel=3; cmplt 20 cycles later -> wrtTmp/mult=0/addr=3'b110, then wrtTmp/mult=1/addr=3'b111, then trmt.
- cmd=4'b1100 (sweep), cmplt 5 cycles after each strt, tx_done 3 cycles after each trmt -> 4 strt with ch_sel 0,1,2,3, 4 trmt, busy low after 4th tx_done.
- TMO_CYC=16, cmd=4'b1001, no cmplt -> err=1 after 16 CONV cycles, no trmt, IDLE; next valid cmd clears err.
- NUM_CH=3: cmd=4'b1011 -> err=1, no strt, busy stays 0.
- Sweep in progress: cmd_rdy pulses ignored (no extra strt); rst_n low during CONV of ch 2 -> all outputs 0 next cycle, no further trmt.
